// File: rtl/str_pkg.sv
// Shared definitions for the UART command-string blocks (str_rec / str_send).
// Contents: reply message identifiers, ASCII control characters, pending-slot record,
//           and the request-priority helper used on the transmit side.
package str_pkg;

  // Reply message identifiers.
  typedef logic [1:0] msg_id_t;
  localparam msg_id_t MSG_START = 2'd0;
  localparam msg_id_t MSG_STOP  = 2'd1;
  localparam msg_id_t MSG_ERR   = 2'd2;

  // ASCII control characters appended as line terminator.
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;

  // One queued request waiting for the current message to finish.
  typedef struct packed {
    logic    vld;
    msg_id_t id;
  } pend_t;

  // Length of the bare word, without line terminator.
  function automatic logic [2:0] msg_word_len(input msg_id_t id);
    return (id == MSG_STOP) ? 3'd4 : 3'd5;
  endfunction

  // Same-cycle request arbitration: stop beats start beats error.
  // Only meaningful when at least one request is active.
  function automatic msg_id_t req_winner(input logic rq_start, input logic rq_stop);
    if (rq_stop) begin
      return MSG_STOP;
    end
    if (rq_start) begin
      return MSG_START;
    end
    return MSG_ERR;
  endfunction

endpackage

// File: rtl/str_rom.sv
// Reply message table: (message id, byte index) -> ASCII byte and message length.
// Latency: purely combinational, no state. Backpressure: not applicable.
// Ports: msg_id_i / index_i select the byte; byte_o is the character (8'h00 past the end),
//        len_o is the full message length including the optional CR LF.
module str_rom #(
  parameter int IW       = 3,
  parameter int ADD_CRLF = 1
) (
  input  logic [1:0]    msg_id_i,
  input  logic [IW-1:0] index_i,
  output logic [7:0]    byte_o,
  output logic [IW:0]   len_o
);
  import str_pkg::*;

  logic [31:0] i32;
  logic [31:0] wl32;

  always_comb begin
    i32    = 32'(index_i);
    wl32   = 32'(msg_word_len(msg_id_i));
    len_o  = (IW+1)'(wl32 + ((ADD_CRLF != 0) ? 32'd2 : 32'd0));
    byte_o = 8'h00;
    if (i32 < wl32) begin
      case (msg_id_i)
        MSG_START: begin
          case (i32)
            32'd0:   byte_o = 8'h73;  // s
            32'd1:   byte_o = 8'h74;  // t
            32'd2:   byte_o = 8'h61;  // a
            32'd3:   byte_o = 8'h72;  // r
            32'd4:   byte_o = 8'h74;  // t
            default: byte_o = 8'h00;
          endcase
        end
        MSG_STOP: begin
          case (i32)
            32'd0:   byte_o = 8'h73;  // s
            32'd1:   byte_o = 8'h74;  // t
            32'd2:   byte_o = 8'h6F;  // o
            32'd3:   byte_o = 8'h70;  // p
            default: byte_o = 8'h00;
          endcase
        end
        MSG_ERR: begin
          case (i32)
            32'd0:   byte_o = 8'h65;  // e
            32'd1:   byte_o = 8'h72;  // r
            32'd2:   byte_o = 8'h72;  // r
            32'd3:   byte_o = 8'h6F;  // o
            32'd4:   byte_o = 8'h72;  // r
            default: byte_o = 8'h00;
          endcase
        end
        default: byte_o = 8'h00;
      endcase
    end else if ((ADD_CRLF != 0) && (i32 == wl32)) begin
      byte_o = CH_CR;
    end else if ((ADD_CRLF != 0) && (i32 == wl32 + 32'd1)) begin
      byte_o = CH_LF;
    end
  end

endmodule

// File: rtl/str_send.sv
// Streams a fixed ASCII reply ("start"/"stop"/"error", optional CR LF) to the UART TX byte port.
// Latency: byte0 is presented the cycle after the request; one byte per cycle at full rate.
// Backpressure: valid/ready; byte held stable while send_ready=0; one pending request is queued.
// Ports: clk/rst (async active-high); req_start/req_stop/req_err one-cycle request pulses;
//        send_ready in, send_valid/send_data out (byte handshake); busy while sending,
//        done pulse after the last byte, dropped pulse when a request finds the pending slot full.
module str_send #(
  parameter int MAX_LEN  = 8,
  parameter int ADD_CRLF = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_start,
  input  logic       req_stop,
  input  logic       req_err,
  input  logic       send_ready,
  output logic       send_valid,
  output logic [7:0] send_data,
  output logic       busy,
  output logic       done,
  output logic       dropped
);
  import str_pkg::*;

  localparam int IW      = $clog2(MAX_LEN);
  localparam int MSG_MAX = (ADD_CRLF != 0) ? 7 : 5;

  // The index counter must be able to address the longest reply.
  if (MAX_LEN < MSG_MAX) begin : g_bad_max_len
    $error("str_send: MAX_LEN is smaller than the longest reply");
  end

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [IW:0] LEN_ONE = (IW+1)'(1);

  logic [1:0]    state_q, state_d;
  msg_id_t       msg_q,   msg_d;
  logic [IW-1:0] idx_q,   idx_d;
  pend_t         pend_q,  pend_d;
  logic          vld_q,   vld_d;
  logic [7:0]    dat_q,   dat_d;
  logic          busy_q,  busy_d;
  logic          done_q,  done_d;
  logic          drop_q,  drop_d;

  logic          req_any;
  msg_id_t       req_id;
  logic          launch;
  msg_id_t       launch_id;
  msg_id_t       rom_id;
  logic [IW-1:0] rom_idx;
  logic [7:0]    rom_byte;
  logic [IW:0]   rom_len;
  logic          last;

  assign req_any = req_start | req_stop | req_err;
  assign req_id  = req_winner(req_start, req_stop);

  // Decide whether a new message begins at the coming edge. In DONE the queued
  // request has precedence; with an empty slot a fresh request starts directly,
  // which is the same as queueing it and consuming it in the same cycle.
  always_comb begin
    launch    = 1'b0;
    launch_id = req_id;
    case (state_q)
      ST_IDLE: launch = req_any;
      ST_DONE: begin
        if (pend_q.vld) begin
          launch    = 1'b1;
          launch_id = pend_q.id;
        end else begin
          launch = req_any;
        end
      end
      default: launch = 1'b0;
    endcase
  end

  // One table lookup serves both cases: byte0 of a new message, or the byte
  // after the one currently on the port.
  assign rom_id  = launch ? launch_id : msg_q;
  assign rom_idx = launch ? '0 : idx_q + IW'(1);
  assign last    = ({1'b0, idx_q} == (rom_len - LEN_ONE));

  str_rom #(
    .IW       (IW),
    .ADD_CRLF (ADD_CRLF)
  ) u_rom (
    .msg_id_i (rom_id),
    .index_i  (rom_idx),
    .byte_o   (rom_byte),
    .len_o    (rom_len)
  );

  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    vld_d   = vld_q;
    dat_d   = dat_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    drop_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // handled by the launch path below
      end
      ST_SEND: begin
        if (req_any) begin
          if (!pend_q.vld) begin
            pend_d.vld = 1'b1;
            pend_d.id  = req_id;
          end else begin
            drop_d = 1'b1;
          end
        end
        if (vld_q && send_ready) begin
          if (last) begin
            state_d = ST_DONE;
            vld_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IW'(1);
            dat_d = rom_byte;
          end
        end
      end
      ST_DONE: begin
        if (pend_q.vld) begin
          // slot is consumed now, so any request this cycle still sees it full
          pend_d = '0;
          drop_d = req_any;
        end
        if (!launch) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (launch) begin
      state_d = ST_SEND;
      msg_d   = launch_id;
      idx_d   = '0;
      vld_d   = 1'b1;
      dat_d   = rom_byte;
      busy_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      msg_q   <= MSG_START;
      idx_q   <= '0;
      pend_q  <= '0;
      vld_q   <= 1'b0;
      dat_q   <= 8'h00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      vld_q   <= vld_d;
      dat_q   <= dat_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
    end
  end

  assign send_valid = vld_q;
  assign send_data  = dat_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign dropped    = drop_q;

endmodule

// File: tb/tb_str_send.sv
// Self-checking bench for str_send: vector table, directed multi-cycle sequences,
// and a randomized run against a message-level reference model.
module tb_str_send;

  logic       clk;
  logic       rst;
  logic       req_start, req_stop, req_err, send_ready;
  logic       send_valid, busy, done, dropped;
  logic [7:0] send_data;

  logic       r0_start, r0_stop, r0_err, r0_ready;
  logic       r0_valid, r0_busy, r0_done, r0_dropped;
  logic [7:0] r0_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  str_send #(.MAX_LEN(8), .ADD_CRLF(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_start  (req_start),
    .req_stop   (req_stop),
    .req_err    (req_err),
    .send_ready (send_ready),
    .send_valid (send_valid),
    .send_data  (send_data),
    .busy       (busy),
    .done       (done),
    .dropped    (dropped)
  );

  str_send #(.MAX_LEN(8), .ADD_CRLF(0)) dut0 (
    .clk        (clk),
    .rst        (rst),
    .req_start  (r0_start),
    .req_stop   (r0_stop),
    .req_err    (r0_err),
    .send_ready (r0_ready),
    .send_valid (r0_valid),
    .send_data  (r0_data),
    .busy       (r0_busy),
    .done       (r0_done),
    .dropped    (r0_dropped)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reply text as the far end should receive it. id: 0 start, 1 stop, 2 error.
  function automatic string exp_text(input int id, input bit crlf);
    string w;
    w = (id == 1) ? "stop" : ((id == 0) ? "start" : "error");
    if (crlf) w = $sformatf("%s%c%c", w, 8'h0D, 8'h0A);
    return w;
  endfunction

  // ---------------- reference model (message level) ----------------
  logic [7:0] m_q[$];   // bytes still to be delivered for the current message
  bit         m_done;   // this cycle is the done cycle after a message
  bit         m_drop;
  bit         m_pv;
  int         m_pid;

  task automatic m_load(input int id);
    string s;
    s = exp_text(id, 1'b1);
    for (int i = 0; i < s.len(); i++) m_q.push_back(s[i]);
  endtask

  // Advance the model over one clock edge given the inputs seen before it.
  task automatic m_step(input bit rs, input bit rp, input bit re, input bit rdy);
    bit any;
    int w;
    bit nd;
    bit ndr;
    any = rs | rp | re;
    w   = rp ? 1 : (rs ? 0 : 2);
    nd  = 1'b0;
    ndr = 1'b0;
    if (m_q.size() > 0) begin
      if (any) begin
        if (!m_pv) begin
          m_pv  = 1'b1;
          m_pid = w;
        end else begin
          ndr = 1'b1;
        end
      end
      if (rdy) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) nd = 1'b1;
      end
    end else if (m_done && m_pv) begin
      m_load(m_pid);
      m_pv = 1'b0;
      ndr  = any;
    end else if (any) begin
      m_load(w);
    end
    m_done = nd;
    m_drop = ndr;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic       rs;
    logic       rp;
    logic       re;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic       eb;
    logic       edn;
    logic       edr;
  } vec_t;

  function automatic vec_t mk(input logic rs, input logic rp, input logic re, input logic rdy,
                              input logic ev, input logic [7:0] ed, input logic eb,
                              input logic edn, input logic edr);
    vec_t v;
    v.rs = rs; v.rp = rp; v.re = re; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.eb = eb; v.edn = edn; v.edr = edr;
    return v;
  endfunction

  vec_t tv[18];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    string      s1;
    string      s2;
    logic [7:0] got[$];
    bit         seen_done;
    logic       pv;
    logic [7:0] pd;
    bit         rs, rp, re, rdy;
    bit         ev;
    logic [7:0] ed;

    //            rs rp re rdy  ev  data   busy done drop
    tv[0]  = mk(0, 0, 0, 1,   0, 8'h00, 0,   0,   0);
    tv[1]  = mk(1, 0, 0, 1,   1, 8'h73, 1,   0,   0);
    tv[2]  = mk(0, 0, 0, 1,   1, 8'h74, 1,   0,   0);
    tv[3]  = mk(0, 0, 0, 1,   1, 8'h61, 1,   0,   0);
    tv[4]  = mk(0, 0, 0, 1,   1, 8'h72, 1,   0,   0);
    tv[5]  = mk(0, 0, 0, 1,   1, 8'h74, 1,   0,   0);
    tv[6]  = mk(0, 0, 0, 1,   1, 8'h0D, 1,   0,   0);
    tv[7]  = mk(0, 0, 0, 1,   1, 8'h0A, 1,   0,   0);
    tv[8]  = mk(0, 0, 0, 1,   0, 8'h00, 0,   1,   0);
    tv[9]  = mk(0, 0, 0, 1,   0, 8'h00, 0,   0,   0);
    tv[10] = mk(1, 1, 0, 1,   1, 8'h73, 1,   0,   0);
    tv[11] = mk(0, 0, 0, 1,   1, 8'h74, 1,   0,   0);
    tv[12] = mk(0, 0, 0, 1,   1, 8'h6F, 1,   0,   0);
    tv[13] = mk(0, 0, 0, 1,   1, 8'h70, 1,   0,   0);
    tv[14] = mk(0, 0, 0, 1,   1, 8'h0D, 1,   0,   0);
    tv[15] = mk(0, 0, 0, 1,   1, 8'h0A, 1,   0,   0);
    tv[16] = mk(0, 0, 0, 1,   0, 8'h00, 0,   1,   0);
    tv[17] = mk(0, 0, 0, 1,   0, 8'h00, 0,   0,   0);

    rst = 1'b1;
    req_start = 1'b0; req_stop = 1'b0; req_err = 1'b0; send_ready = 1'b1;
    r0_start = 1'b0; r0_stop = 1'b0; r0_err = 1'b0; r0_ready = 1'b1;

    // reset state
    #2;
    chk("rst_valid",   32'(send_valid), 32'd0);
    chk("rst_data",    32'(send_data),  32'h00);
    chk("rst_busy",    32'(busy),       32'd0);
    chk("rst_done",    32'(done),       32'd0);
    chk("rst_dropped", 32'(dropped),    32'd0);
    tick; tick;
    rst = 1'b0;

    // table: single start at full rate, then simultaneous start+stop
    for (int i = 0; i < 18; i++) begin
      req_start = tv[i].rs; req_stop = tv[i].rp; req_err = tv[i].re; send_ready = tv[i].rdy;
      tick;
      chk($sformatf("vec%0d_valid", i), 32'(send_valid), 32'(tv[i].ev));
      if (tv[i].ev) chk($sformatf("vec%0d_data", i), 32'(send_data), 32'(tv[i].ed));
      chk($sformatf("vec%0d_busy", i),    32'(busy),    32'(tv[i].eb));
      chk($sformatf("vec%0d_done", i),    32'(done),    32'(tv[i].edn));
      chk($sformatf("vec%0d_dropped", i), 32'(dropped), 32'(tv[i].edr));
    end
    req_start = 1'b0; req_stop = 1'b0; req_err = 1'b0;

    // backpressure: ready pattern 1,0,0,1 while sending "stop"
    req_stop = 1'b1; send_ready = 1'b1;
    tick;
    req_stop = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 60 && !seen_done; c++) begin
      pv = send_valid;
      pd = send_data;
      send_ready = ((c % 4) == 0) || ((c % 4) == 3);
      tick;
      if (pv && send_ready) begin
        got.push_back(pd);
      end else if (pv) begin
        chk("bp_hold_valid", 32'(send_valid), 32'd1);
        chk("bp_hold_data",  32'(send_data),  32'(pd));
      end
      if (done) seen_done = 1'b1;
    end
    chk("bp_done_seen", 32'(seen_done), 32'd1);
    s1 = exp_text(1, 1'b1);
    chk("bp_len", 32'(got.size()), 32'(s1.len()));
    for (int i = 0; i < s1.len(); i++) begin
      if (i < got.size()) chk($sformatf("bp_byte%0d", i), 32'(got[i]), 32'(s1[i]));
    end
    send_ready = 1'b1;
    tick; tick;

    // queueing: error, start queued, stop dropped
    s1 = exp_text(2, 1'b1);
    s2 = exp_text(0, 1'b1);
    for (int n = 1; n <= 17; n++) begin
      req_err = (n == 1); req_start = (n == 2); req_stop = (n == 4);
      tick;
      req_err = 1'b0; req_start = 1'b0; req_stop = 1'b0;
      ev = 1'b0; ed = 8'h00;
      if (n <= 7) begin
        ev = 1'b1; ed = s1[n-1];
      end else if (n >= 9 && n <= 15) begin
        ev = 1'b1; ed = s2[n-9];
      end
      chk($sformatf("q%0d_valid", n), 32'(send_valid), 32'(ev));
      if (ev) chk($sformatf("q%0d_data", n), 32'(send_data), 32'(ed));
      chk($sformatf("q%0d_busy", n),    32'(busy),    32'(ev));
      chk($sformatf("q%0d_done", n),    32'(done),    32'((n == 8) || (n == 16)));
      chk($sformatf("q%0d_dropped", n), 32'(dropped), 32'(n == 4));
    end

    // reset in the middle of "start", after its 3rd byte was taken
    req_start = 1'b1;
    tick;
    req_start = 1'b0;
    tick; tick; tick;
    rst = 1'b1;
    #1;
    chk("mrst_valid",   32'(send_valid), 32'd0);
    chk("mrst_data",    32'(send_data),  32'h00);
    chk("mrst_busy",    32'(busy),       32'd0);
    chk("mrst_done",    32'(done),       32'd0);
    chk("mrst_dropped", 32'(dropped),    32'd0);
    tick; tick;
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      tick;
      chk($sformatf("post_rst%0d_valid", n), 32'(send_valid), 32'd0);
      chk($sformatf("post_rst%0d_busy", n),  32'(busy),       32'd0);
    end
    req_err = 1'b1;
    tick;
    req_err = 1'b0;
    chk("post_rst_new_valid", 32'(send_valid), 32'd1);
    chk("post_rst_new_data",  32'(send_data),  32'h65);
    for (int n = 0; n < 9; n++) tick;

    // build without CR LF: bare "error"
    s1 = exp_text(2, 1'b0);
    for (int n = 1; n <= 7; n++) begin
      r0_err = (n == 1);
      tick;
      r0_err = 1'b0;
      ev = (n <= 5);
      chk($sformatf("nocrlf%0d_valid", n), 32'(r0_valid), 32'(ev));
      if (ev) chk($sformatf("nocrlf%0d_data", n), 32'(r0_data), 32'(s1[n-1]));
      chk($sformatf("nocrlf%0d_done", n), 32'(r0_done), 32'(n == 6));
    end

    // randomized traffic against the reference model
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    m_q.delete();
    m_done = 1'b0; m_drop = 1'b0; m_pv = 1'b0; m_pid = 0;
    for (int c = 0; c < 3000; c++) begin
      rs  = ($urandom_range(0, 11) == 0);
      rp  = ($urandom_range(0, 11) == 0);
      re  = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      req_start = rs; req_stop = rp; req_err = re; send_ready = rdy;
      m_step(rs, rp, re, rdy);
      tick;
      ev = (m_q.size() > 0);
      chk($sformatf("rnd%0d_valid", c), 32'(send_valid), 32'(ev));
      if (ev) chk($sformatf("rnd%0d_data", c), 32'(send_data), 32'(m_q[0]));
      chk($sformatf("rnd%0d_busy", c),    32'(busy),    32'(ev));
      chk($sformatf("rnd%0d_done", c),    32'(done),    32'(m_done));
      chk($sformatf("rnd%0d_dropped", c), 32'(dropped), 32'(m_drop));
    end
    req_start = 1'b0; req_stop = 1'b0; req_err = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
